// File: rtl/ram_cell_arbiter_if.sv
// Handshake bundle for ram_cell_arbiter: requester ports A and B, RAM pins, status.
interface ram_cell_arbiter_if #(
  parameter int ADDR_W     = 12,
  parameter int WORD_W     = 3,
  parameter int CELL_WORDS = 4
);
  localparam int CELL_W = WORD_W * CELL_WORDS;

  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [CELL_W-1:0] a_wdata;
  logic [CELL_W-1:0] a_rdata;
  logic              a_ack;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [CELL_W-1:0] b_wdata;
  logic [CELL_W-1:0] b_rdata;
  logic              b_ack;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [WORD_W-1:0] mem_wdata;
  logic [WORD_W-1:0] mem_rdata;

  logic              busy;
  logic              owner;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_rdata, a_ack,
    input  b_req, b_we, b_addr, b_wdata,
    output b_rdata, b_ack,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata,
    output busy, owner
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_rdata, a_ack,
    output b_req, b_we, b_addr, b_wdata,
    input  b_rdata, b_ack,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata,
    input  busy, owner
  );
endinterface

// File: rtl/ram_cell_arbiter.sv
// Shares a single-port word RAM between two cell requesters, moving one cell as
// CELL_WORDS words MSW-first. Define RAM_CELL_ARB_FIXED_PRIO_EN to make port A win all ties.
module ram_cell_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int WORD_W     = 3,
  parameter int CELL_WORDS = 4
) (
  input logic               clk,
  input logic               rst_n,
  ram_cell_arbiter_if.slave bus
);
  localparam int CELL_W = WORD_W * CELL_WORDS;
  localparam int CNT_W  = (CELL_WORDS > 1) ? $clog2(CELL_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CELL_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DONE
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_base;
  logic [CELL_W-1:0] r_shift;
  logic              r_owner;
  logic              r_aAck;
  logic              r_bAck;
  logic [CELL_W-1:0] r_aRdata;
  logic [CELL_W-1:0] r_bRdata;
`ifndef RAM_CELL_ARB_FIXED_PRIO_EN
  logic              r_rrLast;
`endif

  logic              w_anyReq;
  logic              w_grantB;
  logic              w_lastWord;
  logic [WORD_W-1:0] w_shiftIn;
  logic [CELL_W-1:0] w_shiftNext;

  assign w_anyReq = bus.a_req | bus.b_req;

`ifdef RAM_CELL_ARB_FIXED_PRIO_EN
  assign w_grantB = bus.b_req & ~bus.a_req;
`else
  // On a tie, B wins only if A was the last port granted.
  assign w_grantB = bus.b_req & (~bus.a_req | ~r_rrLast);
`endif

  assign w_lastWord = (r_cnt == LAST_CNT);

  // One register serves both directions: write data leaves from the top, read words enter at the bottom.
  assign w_shiftIn   = r_we ? '0 : bus.mem_rdata;
  assign w_shiftNext = (r_shift << WORD_W) | CELL_W'(w_shiftIn);

  assign bus.mem_addr  = (r_state == XFER) ? (r_base + ADDR_W'(r_cnt)) : '0;
  assign bus.mem_we    = (r_state == XFER) & r_we;
  assign bus.mem_wdata = bus.mem_we ? r_shift[CELL_W-1 -: WORD_W] : '0;

  assign bus.busy    = (r_state != IDLE);
  assign bus.owner   = r_owner;
  assign bus.a_ack   = r_aAck;
  assign bus.b_ack   = r_bAck;
  assign bus.a_rdata = r_aRdata;
  assign bus.b_rdata = r_bRdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_we     <= 1'b0;
      r_base   <= '0;
      r_shift  <= '0;
      r_owner  <= 1'b0;
      r_aAck   <= 1'b0;
      r_bAck   <= 1'b0;
      r_aRdata <= '0;
      r_bRdata <= '0;
`ifndef RAM_CELL_ARB_FIXED_PRIO_EN
      r_rrLast <= 1'b1;
`endif
    end else begin
      r_aAck <= 1'b0;
      r_bAck <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_anyReq) begin
            r_owner <= w_grantB;
            r_cnt   <= '0;
            r_we    <= w_grantB ? bus.b_we    : bus.a_we;
            r_base  <= w_grantB ? bus.b_addr  : bus.a_addr;
            r_shift <= w_grantB ? bus.b_wdata : bus.a_wdata;
`ifndef RAM_CELL_ARB_FIXED_PRIO_EN
            r_rrLast <= w_grantB;
`endif
            r_state <= XFER;
          end
        end
        XFER: begin
          r_shift <= w_shiftNext;
          r_cnt   <= r_cnt + 1'b1;
          if (w_lastWord) begin
            r_state <= DONE;
            // Rdata of a write is left holding its previous cell.
            if (r_owner) begin
              r_bAck <= 1'b1;
              if (!r_we) r_bRdata <= w_shiftNext;
            end else begin
              r_aAck <= 1'b1;
              if (!r_we) r_aRdata <= w_shiftNext;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ram_cell_arbiter.sv
// Directed self-checking bench for ram_cell_arbiter with a behavioural 4096x3 RAM.
`timescale 1ns/1ps
module tb_ram_cell_arbiter;
  localparam int ADDR_W     = 12;
  localparam int WORD_W     = 3;
  localparam int CELL_WORDS = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  logic [WORD_W-1:0] ram [0:4095];
  logic              pWe;
  logic [ADDR_W-1:0] pAddr;
  logic [WORD_W-1:0] pData;

  ram_cell_arbiter_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .CELL_WORDS(CELL_WORDS)) bus ();

  ram_cell_arbiter #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .CELL_WORDS(CELL_WORDS)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // RAM model: synchronous write, combinational read; pWe is a bench-side preload path.
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    else if (pWe) ram[pAddr] <= pData;
  end
  assign bus.mem_rdata = ram[bus.mem_addr];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit portB, input bit we, input logic [11:0] addr, input logic [11:0] wdata);
    if (portB) begin
      bus.b_req = 1'b1; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wdata;
    end else begin
      bus.a_req = 1'b1; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wdata;
    end
  endtask

  task automatic dropReq();
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;
  endtask

  task automatic pokeRam(input logic [11:0] addr, input logic [2:0] data);
    @(negedge clk);
    pWe = 1'b1; pAddr = addr; pData = data;
  endtask

  task automatic waitAck(output int lat, output int weCycles);
    logic seen = 1'b0;
    lat = 0;
    weCycles = 0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (bus.mem_we) weCycles++;
      seen = bus.a_ack | bus.b_ack;
    end
    checkOutput("ackSeen", 32'(seen), 32'd1);
  endtask

  initial begin
    int lat;
    int weCyc;
    logic [2:0] pre [8] = '{3'd0, 3'd7, 3'd7, 3'd4, 3'd7, 3'd0, 3'd0, 3'd3};

    rst_n = 1'b0;
    pWe = 1'b0; pAddr = '0; pData = '0;
    bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;

    for (int i = 0; i < 8; i++) pokeRam(12'(64 + i), pre[i]);
    pokeRam(12'h002, 3'd5);
    pokeRam(12'h200, 3'd0);
    pokeRam(12'h201, 3'd0);
    pokeRam(12'h202, 3'd1);
    pokeRam(12'h203, 3'd1);
    @(negedge clk);
    pWe = 1'b0;
    @(negedge clk);

    checkOutput("rst busy", bus.busy, 0);
    checkOutput("rst owner", bus.owner, 0);
    checkOutput("rst mem_we", bus.mem_we, 0);
    checkOutput("rst mem_addr", bus.mem_addr, 0);
    checkOutput("rst mem_wdata", bus.mem_wdata, 0);
    checkOutput("rst a_ack", bus.a_ack, 0);
    checkOutput("rst b_ack", bus.b_ack, 0);
    checkOutput("rst a_rdata", bus.a_rdata, 0);
    checkOutput("rst b_rdata", bus.b_rdata, 0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle busy", bus.busy, 0);

    $display("[TB] simultaneous requests from reset");
    applyStimulus(1'b0, 1'b0, 12'd64, 12'h000);
    applyStimulus(1'b1, 1'b0, 12'd68, 12'h000);
    waitAck(lat, weCyc);
    checkOutput("sim1 latency", lat, 5);
    checkOutput("sim1 a_ack", bus.a_ack, 1);
    checkOutput("sim1 b_ack", bus.b_ack, 0);
    checkOutput("sim1 owner", bus.owner, 0);
    checkOutput("sim1 a_rdata", bus.a_rdata, 12'h1FC);
    waitAck(lat, weCyc);
    checkOutput("sim2 latency", lat, 6);
`ifdef RAM_CELL_ARB_FIXED_PRIO_EN
    checkOutput("sim2 a_ack", bus.a_ack, 1);
    checkOutput("sim2 owner", bus.owner, 0);
`else
    checkOutput("sim2 b_ack", bus.b_ack, 1);
    checkOutput("sim2 a_ack", bus.a_ack, 0);
    checkOutput("sim2 owner", bus.owner, 1);
    checkOutput("sim2 b_rdata", bus.b_rdata, 12'hE03);
`endif
    dropReq();
    @(negedge clk);
    checkOutput("sim idle busy", bus.busy, 0);

    $display("[TB] A reads 68");
    applyStimulus(1'b0, 1'b0, 12'd68, 12'h000);
    waitAck(lat, weCyc);
    checkOutput("rdA68 latency", lat, 5);
    checkOutput("rdA68 a_rdata", bus.a_rdata, 12'hE03);
    checkOutput("rdA68 weCycles", weCyc, 0);
    dropReq();
    @(negedge clk);
    checkOutput("rdA68 ack pulse", bus.a_ack, 0);

    $display("[TB] B writes 0xABC at 0x100");
    applyStimulus(1'b1, 1'b1, 12'h100, 12'hABC);
    waitAck(lat, weCyc);
    checkOutput("wrB latency", lat, 5);
    checkOutput("wrB b_ack", bus.b_ack, 1);
    checkOutput("wrB weCycles", weCyc, 4);
    checkOutput("wrB ram", {ram[12'h100], ram[12'h101], ram[12'h102], ram[12'h103]}, 12'hABC);
    checkOutput("wrB a_rdata held", bus.a_rdata, 12'hE03);
    dropReq();
    @(negedge clk);
    checkOutput("wrB ack pulse", bus.b_ack, 0);

    $display("[TB] B reads 0x100");
    applyStimulus(1'b1, 1'b0, 12'h100, 12'h000);
    waitAck(lat, weCyc);
    checkOutput("rdB latency", lat, 5);
    checkOutput("rdB b_rdata", bus.b_rdata, 12'hABC);
    dropReq();
    @(negedge clk);

    $display("[TB] A writes 0x123 at 0xFFE (wrap)");
    applyStimulus(1'b0, 1'b1, 12'hFFE, 12'h123);
    waitAck(lat, weCyc);
    checkOutput("wrap wr a_ack", bus.a_ack, 1);
    checkOutput("wrap ram", {ram[12'hFFE], ram[12'hFFF], ram[12'h000], ram[12'h001]}, 12'h123);
    checkOutput("wrap ram002", ram[12'h002], 5);
    dropReq();
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 12'hFFE, 12'h000);
    waitAck(lat, weCyc);
    checkOutput("wrap rd a_rdata", bus.a_rdata, 12'h123);
    checkOutput("wrap b_rdata held", bus.b_rdata, 12'hABC);
    dropReq();
    @(negedge clk);

    $display("[TB] B holds req through ack");
    applyStimulus(1'b1, 1'b0, 12'h100, 12'h000);
    waitAck(lat, weCyc);
    checkOutput("hold1 b_rdata", bus.b_rdata, 12'hABC);
    bus.b_addr = 12'd64;
    @(negedge clk);
    checkOutput("hold idle busy", bus.busy, 0);
    checkOutput("hold idle b_ack", bus.b_ack, 0);
    @(negedge clk);
    checkOutput("hold2 busy", bus.busy, 1);
    checkOutput("hold2 mem_addr0", bus.mem_addr, 12'd64);
    bus.b_addr = 12'h300;
    @(negedge clk);
    checkOutput("hold2 mem_addr1", bus.mem_addr, 12'd65);
    waitAck(lat, weCyc);
    checkOutput("hold2 latency", lat, 3);
    checkOutput("hold2 b_rdata", bus.b_rdata, 12'h1FC);
    dropReq();
    @(negedge clk);

    $display("[TB] reset during B write");
    applyStimulus(1'b1, 1'b1, 12'h200, 12'hFFF);
    @(negedge clk);
    checkOutput("abort mem_we", bus.mem_we, 1);
    checkOutput("abort mem_addr0", bus.mem_addr, 12'h200);
    checkOutput("abort mem_wdata", bus.mem_wdata, 7);
    @(negedge clk);
    checkOutput("abort mem_addr1", bus.mem_addr, 12'h201);
    rst_n = 1'b0;
    dropReq();
    @(negedge clk);
    checkOutput("abort busy", bus.busy, 0);
    checkOutput("abort mem_we after", bus.mem_we, 0);
    checkOutput("abort mem_addr after", bus.mem_addr, 0);
    checkOutput("abort owner", bus.owner, 0);
    checkOutput("abort b_ack", bus.b_ack, 0);
    checkOutput("abort b_rdata", bus.b_rdata, 0);
    checkOutput("abort a_rdata", bus.a_rdata, 0);
    checkOutput("abort ram", {ram[12'h200], ram[12'h201], ram[12'h202], ram[12'h203]}, 12'hFC9);
    @(negedge clk);
    checkOutput("abort b_ack later", bus.b_ack, 0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] simultaneous requests after reset");
    applyStimulus(1'b0, 1'b0, 12'd64, 12'h000);
    applyStimulus(1'b1, 1'b0, 12'h100, 12'h000);
    waitAck(lat, weCyc);
    checkOutput("sim3 a_ack", bus.a_ack, 1);
    checkOutput("sim3 owner", bus.owner, 0);
    checkOutput("sim3 a_rdata", bus.a_rdata, 12'h1FC);
    dropReq();
    @(negedge clk);
    @(negedge clk);
    checkOutput("final busy", bus.busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
